// File: rtl/imem_uart_loader_if.sv
// Instruction RAM write port driven by the boot loader.
interface imem_uart_loader_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (output we, addr, wdata);
  modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a framed program image over UART, writes big-endian words
// into instruction RAM and holds the core in reset until a checksum-verified load.
module imem_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned TIMEOUT_CYC  = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_uart_rx,
  imem_uart_loader_if.master o_imem,
  output logic               o_cpu_rst,
  output logic               o_load_done,
  output logic               o_load_err,
  output logic               o_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {StIdle, StLenLo, StData, StCksum, StDone, StErr} st_e;

  // Receiver state
  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_e       r_rx_state, w_rx_state_nxt;
  logic [CntW-1:0] r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0]      r_bit_idx, w_bit_idx_nxt;
  logic [7:0]      r_rx_shift, w_rx_shift_nxt;
  logic            r_byte_valid, w_byte_valid_nxt;
  logic            r_frame_err, w_frame_err_nxt;

  // Frame state
  st_e             r_state, w_state_nxt;
  logic [7:0]      r_len_hi, w_len_hi_nxt;
  logic [15:0]     r_len, w_len_nxt;
  logic [15:0]     r_word_idx, w_word_idx_nxt;
  logic [1:0]      r_byte_idx, w_byte_idx_nxt;
  logic [23:0]     r_word, w_word_nxt;
  logic [7:0]      r_xor, w_xor_nxt;
  logic [TmoW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic            r_we, w_we_nxt;
  logic [31:0]     r_addr, w_addr_nxt;
  logic [31:0]     r_wdata, w_wdata_nxt;
  logic            r_cpu_rst, w_cpu_rst_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;

  logic            w_frame_active;
  logic [15:0]     w_len;

  assign w_frame_active = (r_state == StLenLo) || (r_state == StData) || (r_state == StCksum);
  assign w_len          = {r_len_hi, r_rx_shift};

  // Synchronise the asynchronous serial line and keep one cycle of history for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // Receiver next state: start-bit recheck at half bit, data and stop sampled at bit centres.
  always_comb begin
    w_rx_state_nxt   = r_rx_state;
    w_clk_cnt_nxt    = r_clk_cnt + CntW'(1);
    w_bit_idx_nxt    = r_bit_idx;
    w_rx_shift_nxt   = r_rx_shift;
    w_byte_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    unique case (r_rx_state)
      RxIdle: begin
        w_clk_cnt_nxt = '0;
        // Once loaded the line is ignored entirely.
        if (r_rx_prev && !r_rx_sync && (r_state != StDone)) w_rx_state_nxt = RxStart;
      end
      RxStart: begin
        if (r_clk_cnt == HalfLast) begin
          w_clk_cnt_nxt  = '0;
          w_bit_idx_nxt  = '0;
          w_rx_state_nxt = r_rx_sync ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (r_clk_cnt == BitLast) begin
          w_clk_cnt_nxt  = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          w_bit_idx_nxt  = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_rx_state_nxt = RxStop;
        end
      end
      RxStop: begin
        if (r_clk_cnt == BitLast) begin
          w_clk_cnt_nxt    = '0;
          w_rx_state_nxt   = RxIdle;
          w_byte_valid_nxt = r_rx_sync;
          w_frame_err_nxt  = !r_rx_sync;
        end
      end
      default: w_rx_state_nxt = RxIdle;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_state   <= RxIdle;
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_nxt;
      r_clk_cnt    <= w_clk_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  // Frame parser next state: length, data words, checksum, plus error and timeout handling.
  always_comb begin
    w_state_nxt    = r_state;
    w_len_hi_nxt   = r_len_hi;
    w_len_nxt      = r_len;
    w_word_idx_nxt = r_word_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_word_nxt     = r_word;
    w_xor_nxt      = r_xor;
    w_we_nxt       = 1'b0;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_cpu_rst_nxt  = r_cpu_rst;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_tmo_cnt_nxt  = (r_byte_valid || !w_frame_active) ? '0 : r_tmo_cnt + TmoW'(1);

    unique case (r_state)
      StIdle: begin
        if (r_byte_valid) begin
          w_len_hi_nxt = r_rx_shift;
          w_xor_nxt    = r_rx_shift;
          w_err_nxt    = 1'b0;
          w_state_nxt  = StLenLo;
        end else if (r_frame_err) begin
          w_err_nxt = 1'b1;
        end
      end
      StLenLo: begin
        if (r_frame_err) begin
          w_state_nxt = StErr;
          w_err_nxt   = 1'b1;
        end else if (r_byte_valid) begin
          w_len_nxt      = w_len;
          w_xor_nxt      = r_xor ^ r_rx_shift;
          w_word_idx_nxt = '0;
          w_byte_idx_nxt = '0;
          if (32'(w_len) > DEPTH) begin
            w_state_nxt = StErr;
            w_err_nxt   = 1'b1;
          end else if (w_len == 16'd0) begin
            w_state_nxt = StCksum;
          end else begin
            w_state_nxt = StData;
          end
        end else if (r_tmo_cnt == TmoLast) begin
          w_state_nxt = StErr;
          w_err_nxt   = 1'b1;
        end
      end
      StData: begin
        if (r_frame_err) begin
          w_state_nxt = StErr;
          w_err_nxt   = 1'b1;
        end else if (r_byte_valid) begin
          w_xor_nxt      = r_xor ^ r_rx_shift;
          w_word_nxt     = {r_word[15:0], r_rx_shift};
          w_byte_idx_nxt = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            w_we_nxt       = 1'b1;
            w_addr_nxt     = {14'd0, r_word_idx, 2'b00};
            w_wdata_nxt    = {r_word, r_rx_shift};
            w_word_idx_nxt = r_word_idx + 16'd1;
            if (r_word_idx == r_len - 16'd1) w_state_nxt = StCksum;
          end
        end else if (r_tmo_cnt == TmoLast) begin
          w_state_nxt = StErr;
          w_err_nxt   = 1'b1;
        end
      end
      StCksum: begin
        if (r_frame_err) begin
          w_state_nxt = StErr;
          w_err_nxt   = 1'b1;
        end else if (r_byte_valid) begin
          if (r_rx_shift == r_xor) begin
            w_state_nxt   = StDone;
            w_done_nxt    = 1'b1;
            w_cpu_rst_nxt = 1'b0;
          end else begin
            w_state_nxt = StErr;
            w_err_nxt   = 1'b1;
          end
        end else if (r_tmo_cnt == TmoLast) begin
          w_state_nxt = StErr;
          w_err_nxt   = 1'b1;
        end
      end
      StDone:  w_state_nxt = StDone;
      StErr:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Frame parser state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_xor      <= '0;
      r_tmo_cnt  <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_len_hi   <= w_len_hi_nxt;
      r_len      <= w_len_nxt;
      r_word_idx <= w_word_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_word     <= w_word_nxt;
      r_xor      <= w_xor_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_cpu_rst  <= w_cpu_rst_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign o_imem.we    = r_we;
  assign o_imem.addr  = r_addr;
  assign o_imem.wdata = r_wdata;
  assign o_cpu_rst    = r_cpu_rst;
  assign o_load_done  = r_done;
  assign o_load_err   = r_err;
  assign o_busy       = w_frame_active || (r_rx_state != RxIdle);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: UART frame driver, write scoreboard and status checks.
module tb_imem_uart_loader;
  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic cpu_rst, load_done, load_err, busy;

  imem_uart_loader_if bus ();

  imem_uart_loader #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_uart_rx   (rx),
    .o_imem      (bus),
    .o_cpu_rst   (cpu_rst),
    .o_load_done (load_done),
    .o_load_err  (load_err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [63:0] exp_q[$];  // {addr, data} of each write the reference expects
  logic [31:0] words[DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard queue.
  logic prev_done = 1'b0;
  logic prev_cpu_rst = 1'b1;
  always @(negedge clk) begin
    logic [63:0] e;
    if (bus.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_write: got addr %h data %h, want no write", bus.addr, bus.wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", bus.addr, e[63:32]);
        chk("write_data", bus.wdata, e[31:0]);
      end
    end
    if (load_done !== prev_done || cpu_rst !== prev_cpu_rst)
      chk("done_vs_cpu_rst", {31'd0, load_done}, {31'd0, ~cpu_rst});
    prev_done    = load_done;
    prev_cpu_rst = cpu_rst;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (!stop_ok) begin
      drive_bit(1'b1);
      drive_bit(1'b1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},      {31'd0, bus.we},    32'd0);
    chk({tag, "_addr"},    bus.addr,           32'd0);
    chk({tag, "_wdata"},   bus.wdata,          32'd0);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst},   32'd1);
    chk({tag, "_done"},    {31'd0, load_done}, 32'd0);
    chk({tag, "_err"},     {31'd0, load_err},  32'd0);
    chk({tag, "_busy"},    {31'd0, busy},      32'd0);
  endtask

  // Sends a frame of n words from words[]; the checksum is the XOR of all earlier bytes,
  // optionally corrupted. Every word is expected to be written regardless of the checksum.
  task automatic run_frame(input int n, input bit corrupt, input bit chk_clear);
    logic [7:0] ck;
    logic [7:0] b;
    logic [31:0] w;
    ck = n[15:8] ^ n[7:0];
    send_byte(n[15:8]);
    if (chk_clear) chk("err_clears_on_len_hi", {31'd0, load_err}, 32'd0);
    send_byte(n[7:0]);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      exp_q.push_back({32'(i) * 32'd4, w});
      for (int k = 3; k >= 0; k--) begin
        b  = w[k*8 +: 8];
        ck = ck ^ b;
        send_byte(b);
      end
    end
    if (corrupt) ck = ck ^ 8'h5A;
    send_byte(ck);
    chk("frame_done",    {31'd0, load_done}, {31'd0, ~corrupt});
    chk("frame_cpu_rst", {31'd0, cpu_rst},   {31'd0, corrupt});
    chk("frame_err",     {31'd0, load_err},  {31'd0, corrupt});
    idle(2);
    chk("frame_busy",    {31'd0, busy},      32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();
    chk_reset_vals("reset");

    // Two-word program, good checksum.
    words[0] = 32'h2008_0005;
    words[1] = 32'h2009_000A;
    run_frame(2, 1'b0, 1'b0);

    // Same program with a bad checksum, then a clean resend.
    do_reset();
    run_frame(2, 1'b1, 1'b0);
    run_frame(2, 1'b0, 1'b1);

    // Oversized length: error without any write.
    do_reset();
    send_byte(8'h01);
    send_byte(8'h01);
    idle(4);
    chk("len257_err",  {31'd0, load_err},  32'd1);
    chk("len257_done", {31'd0, load_done}, 32'd0);
    chk("len257_busy", {31'd0, busy},      32'd0);
    n = DEPTH + 1;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    idle(4);
    chk("len_depth_plus1_err", {31'd0, load_err}, 32'd1);

    // Empty program.
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("len0_done",    {31'd0, load_done}, 32'd1);
    chk("len0_cpu_rst", {31'd0, cpu_rst},   32'd0);
    chk("len0_err",     {31'd0, load_err},  32'd0);

    // Short low glitch on an idle line must be ignored.
    do_reset();
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(2 * CPB);
    chk("glitch_busy", {31'd0, busy},     32'd0);
    chk("glitch_err",  {31'd0, load_err}, 32'd0);

    // Framing error inside DATA after one complete word.
    words[0] = $urandom;
    send_byte(8'h00);
    send_byte(8'h02);
    exp_q.push_back({32'd0, words[0]});
    for (int k = 3; k >= 0; k--) send_byte(words[0][k*8 +: 8]);
    send_byte(8'h33, 1'b0);
    chk("stopbit_err",     {31'd0, load_err}, 32'd1);
    chk("stopbit_busy",    {31'd0, busy},     32'd0);
    chk("stopbit_cpu_rst", {31'd0, cpu_rst},  32'd1);

    // Inter-byte timeout after the length bytes.
    do_reset();
    send_byte(8'h00);
    send_byte(8'h02);
    idle(TMO - 20);
    chk("tmo_before_err",  {31'd0, load_err}, 32'd0);
    chk("tmo_before_busy", {31'd0, busy},     32'd1);
    idle(30);
    chk("tmo_after_err",  {31'd0, load_err}, 32'd1);
    chk("tmo_after_busy", {31'd0, busy},     32'd0);

    // Reset in the middle of word 1 of a four-word frame.
    do_reset();
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    send_byte(8'h00);
    send_byte(8'h04);
    exp_q.push_back({32'd0, words[0]});
    for (int k = 3; k >= 0; k--) send_byte(words[0][k*8 +: 8]);
    send_byte(words[1][31:24]);
    send_byte(words[1][23:16]);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    idle(1);
    chk_reset_vals("midreset");
    idle(2);
    rst = 1'b0;
    idle(12 * CPB);
    chk_reset_vals("after_midreset");
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    run_frame(4, 1'b0, 1'b0);

    // Randomised frames, including a full-depth image.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = (r == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) words[i] = $urandom;
      run_frame(n, 1'($urandom_range(0, 1)), 1'b0);
    end

    idle(4);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
